// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes SPI command words into RAM cycles and shares the single RAM port with a host, round-robin.
// Latency: SPI strobe -> RAM cycle 2 clk, SPI read data 4 clk; host_req -> host_gnt/RAM 1 clk, host read data 3 clk.
// Backpressure: none on SPI (one pending data command, extras dropped and flagged on spi_ovf); host holds host_req until host_gnt.
// Optional feature: define SPI_ARB_AUTO_INC_EN to post-increment wr_addr/rd_addr after each SPI write/read access.
module spi_ram_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8   // must not exceed ADDR_WIDTH: write data comes from the command payload
) (
   input  logic                  clk,
   input  logic                  rst,
   // SPI slave side
   input  logic [ADDR_WIDTH+1:0] rx_data,
   input  logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_valid,
   // parallel host side
   input  logic                  host_req,
   input  logic                  host_we,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0] host_wdata,
   output logic                  host_gnt,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic                  host_rvalid,
   // single-port RAM side
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   // status
   output logic                  spi_ovf
);

   // Command opcodes carried in the top two bits of the SPI word.
   localparam logic [1:0] OP_WADDR = 2'b00;
   localparam logic [1:0] OP_RADDR = 2'b10;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      SPI_ACC  = 2'b01,
      HOST_ACC = 2'b10,
      RD_WAIT  = 2'b11
   } state_t;

   state_t                  state;
   state_t                  state_nx;

   logic [1:0]              opcode;
   logic [ADDR_WIDTH-1:0]   payload;
   logic                    data_cmd;     // opcode 01 or 11: needs a RAM cycle

   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [ADDR_WIDTH-1:0]   rd_addr;

   // One-deep holding slot for an SPI data command waiting for the RAM.
   logic                    spi_pend;
   logic                    spi_pend_rd;  // 1 = read (opcode 11), 0 = write (opcode 01)
   logic [DATA_WIDTH-1:0]   spi_pend_dat;

   logic                    last_spi;     // 1 = most recent grant went to SPI; reset favours SPI on first conflict
   logic                    rd_owner_spi; // which side the read in RD_WAIT belongs to

   assign opcode   = rx_data[ADDR_WIDTH+1 -: 2];
   assign payload  = rx_data[ADDR_WIDTH-1:0];
   assign data_cmd = rx_valid & opcode[0];

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Arbitration, next-state and RAM port drive; RAM port is quiet outside the access states.
   always_comb begin
      state_nx = state;
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      host_gnt = 1'b0;
      case (state)
         IDLE: begin
            // SPI wins when alone, or when contending and the host was served last.
            if (spi_pend && (!host_req || !last_spi)) begin
               state_nx = SPI_ACC;
            end else if (host_req) begin
               state_nx = HOST_ACC;
            end
         end
         SPI_ACC: begin
            ram_en   = 1'b1;
            ram_we   = ~spi_pend_rd;
            ram_addr = spi_pend_rd ? rd_addr : wr_addr;
            ram_din  = spi_pend_rd ? '0 : spi_pend_dat;
            state_nx = spi_pend_rd ? RD_WAIT : IDLE;
         end
         HOST_ACC: begin
            ram_en   = 1'b1;
            ram_we   = host_we;
            ram_addr = host_addr;
            ram_din  = host_we ? host_wdata : '0;
            host_gnt = 1'b1;
            state_nx = host_we ? IDLE : RD_WAIT;
         end
         RD_WAIT: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Round-robin memory and read-owner tracking, updated in the access cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_spi     <= 1'b0;
         rd_owner_spi <= 1'b0;
      end else if (state == SPI_ACC) begin
         last_spi     <= 1'b1;
         rd_owner_spi <= 1'b1;
      end else if (state == HOST_ACC) begin
         last_spi     <= 1'b0;
         rd_owner_spi <= 1'b0;
      end
   end

   // Pending SPI data command: cleared when served, refilled only when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_pend     <= 1'b0;
         spi_pend_rd  <= 1'b0;
         spi_pend_dat <= '0;
      end else begin
         if (state == SPI_ACC) begin
            spi_pend <= 1'b0;
         end
         // SPI_ACC implies spi_pend=1, so a refill never collides with the clear.
         if (data_cmd && !spi_pend) begin
            spi_pend     <= 1'b1;
            spi_pend_rd  <= opcode[1];
            spi_pend_dat <= payload[DATA_WIDTH-1:0];
         end
      end
   end

   // Sticky overflow: a data command arrived while the slot was still occupied.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_ovf <= 1'b0;
      end else if (data_cmd && spi_pend) begin
         spi_ovf <= 1'b1;
      end
   end

   // Address registers: optional post-increment after SPI accesses, an explicit latch in the same cycle takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_addr <= '0;
         rd_addr <= '0;
      end else begin
`ifdef SPI_ARB_AUTO_INC_EN
         if (state == SPI_ACC && !spi_pend_rd) begin
            wr_addr <= wr_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         end
         if (state == SPI_ACC && spi_pend_rd) begin
            rd_addr <= rd_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         end
`endif
         if (rx_valid && opcode == OP_WADDR) begin
            wr_addr <= payload;
         end
         if (rx_valid && opcode == OP_RADDR) begin
            rd_addr <= payload;
         end
      end
   end

   // Read return: capture RAM data in RD_WAIT and strobe the owning side one cycle later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_data     <= '0;
         tx_valid    <= 1'b0;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
      end else begin
         tx_valid    <= 1'b0;
         host_rvalid <= 1'b0;
         if (state == RD_WAIT) begin
            if (rd_owner_spi) begin
               tx_data  <= ram_dout;
               tx_valid <= 1'b1;
            end else begin
               host_rdata  <= ram_dout;
               host_rvalid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed SPI/host traffic against a timestamp-based access model and a behavioural RAM.
// Every cycle outside reset the full output vector is compared with the model; literal checks pin key timings and data.
// Honours SPI_ARB_AUTO_INC_EN the same way the design does.
module tb_spi_ram_arbiter;

   logic       clk;
   logic       rst;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       host_req;
   logic       host_we;
   logic [7:0] host_addr;
   logic [7:0] host_wdata;
   logic       host_gnt;
   logic [7:0] host_rdata;
   logic       host_rvalid;
   logic       ram_en;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_din;
   logic [7:0] ram_dout;
   logic       spi_ovf;

   int n_chk  = 0;
   int n_pass = 0;

   spi_ram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
      .spi_ovf(spi_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM with registered read.
   logic [7:0] mem [256] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_din;
         else        ram_dout      <= mem[ram_addr];
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // ---------------- access model ----------------
   // Works in absolute cycle numbers: when the port is next free, when a granted access lands,
   // and when read data is due; registers hold the values visible in the coming cycle.
   int         cyc      = 0;
   int         free_at  = 0;
   int         acc_cyc  = -1;
   int         acc_who  = 0;     // 1 = SPI, 2 = host
   logic       acc_we   = 1'b0;
   logic [7:0] acc_addr = 8'h00;
   logic [7:0] acc_din  = 8'h00;
   int         rv_cyc   = -1;
   int         rv_who   = 0;
   logic [7:0] rv_dat   = 8'h00;
   logic [7:0] m_wr = 8'h00, m_rd = 8'h00, m_pdat = 8'h00, m_txd = 8'h00, m_hrd = 8'h00;
   logic       m_pend = 1'b0, m_pop_rd = 1'b0, m_ovf = 1'b0, m_last_spi = 1'b0;
   logic [7:0] mdl_mem [256] = '{default: 8'h00};
   logic [37:0] exp_vec = '0;

   initial begin
      int c;
      int g;
      logic old_pend;
      logic e_en, e_we, e_gnt, e_txv, e_hrv;
      logic [7:0] e_addr, e_din;
      forever begin
         @(posedge clk);
         c = cyc;
         cyc++;
         if (rst) begin
            free_at = 0; acc_cyc = -1; rv_cyc = -1;
            m_wr = 0; m_rd = 0; m_pdat = 0; m_txd = 0; m_hrd = 0;
            m_pend = 0; m_pop_rd = 0; m_ovf = 0; m_last_spi = 0;
            exp_vec = '0;
         end else begin
            old_pend = m_pend;
            // who wins the port in the cycle that just ended
            g = 0;
            if (c >= free_at && (m_pend || host_req)) begin
               if (m_pend && host_req) g = m_last_spi ? 2 : 1;
               else                    g = m_pend ? 1 : 2;
            end
            // effects of an access that occupied the ended cycle
            if (acc_cyc == c) begin
               m_last_spi = (acc_who == 1);
               if (acc_who == 1) m_pend = 1'b0;
               if (acc_we) mdl_mem[acc_addr] = acc_din;
               else begin rv_cyc = c + 2; rv_who = acc_who; rv_dat = mdl_mem[acc_addr]; end
`ifdef SPI_ARB_AUTO_INC_EN
               if (acc_who == 1) begin
                  if (acc_we) m_wr = m_wr + 8'd1;
                  else        m_rd = m_rd + 8'd1;
               end
`endif
            end
            // SPI command seen in the ended cycle
            if (rx_valid) begin
               case (rx_data[9:8])
                  2'b00: m_wr = rx_data[7:0];
                  2'b10: m_rd = rx_data[7:0];
                  default: begin
                     if (old_pend) m_ovf = 1'b1;
                     else begin m_pend = 1'b1; m_pop_rd = rx_data[9]; m_pdat = rx_data[7:0]; end
                  end
               endcase
            end
            // book the granted access for the next cycle
            if (g != 0) begin
               acc_cyc = c + 1;
               acc_who = g;
               if (g == 1) acc_we = !m_pop_rd;
               else begin
                  acc_we   = host_we;
                  acc_addr = host_addr;
                  acc_din  = host_we ? host_wdata : 8'h00;
               end
               free_at = c + (acc_we ? 2 : 3);
            end
            // expected outputs for the coming cycle
            e_en = 0; e_we = 0; e_addr = 0; e_din = 0; e_gnt = 0; e_txv = 0; e_hrv = 0;
            if (acc_cyc == c + 1) begin
               if (acc_who == 1) begin
                  acc_addr = acc_we ? m_wr : m_rd;
                  acc_din  = acc_we ? m_pdat : 8'h00;
               end
               e_en = 1; e_we = acc_we; e_addr = acc_addr; e_din = acc_din; e_gnt = (acc_who == 2);
            end
            if (rv_cyc == c + 1) begin
               if (rv_who == 1) begin e_txv = 1; m_txd = rv_dat; end
               else             begin e_hrv = 1; m_hrd = rv_dat; end
            end
            exp_vec = {e_en, e_we, e_addr, e_din, e_gnt, e_txv, m_txd, e_hrv, m_hrd, m_ovf};
         end
      end
   end

   // Cycle compare against the model, plus a record of grant order (0 = SPI, 1 = host).
   bit gq[$];
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("cycle_outputs",
                {ram_en, ram_we, ram_addr, ram_din, host_gnt, tx_valid, tx_data, host_rvalid, host_rdata, spi_ovf},
                exp_vec);
            if (ram_en) gq.push_back(host_gnt);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_cyc(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic spi(input logic [1:0] op, input logic [7:0] pl);
      rx_valid = 1'b1;
      rx_data  = {op, pl};
      wait_cyc(1);
      rx_valid = 1'b0;
      rx_data  = '0;
   endtask

   task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int waited);
      int n;
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; rd = '0;
      waited = 0;
      do begin wait_cyc(1); waited++; end while (!host_gnt && waited < 20);
      chk("host_gnt_seen", host_gnt, 1);
      host_req = 1'b0;
      if (!we) begin
         n = 0;
         do begin wait_cyc(1); n++; end while (!host_rvalid && n < 10);
         chk("host_rvalid_seen", host_rvalid, 1);
         chk("host_rvalid_latency", n, 2);
         rd = host_rdata;
      end
   endtask

   initial begin
      logic [7:0] rd;
      int         w;
      logic [4:0] order;
      rst = 1'b1; rx_valid = 0; rx_data = '0;
      host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
      wait_cyc(3);
      rst = 1'b0;
      chk("reset_outputs",
          {ram_en, ram_we, ram_addr, ram_din, host_gnt, tx_valid, tx_data, host_rvalid, host_rdata, spi_ovf}, 0);
      wait_cyc(2);

      // SPI write: ram cycle two clocks after the data strobe
      spi(2'b00, 8'h12);
      spi(2'b01, 8'hA5);
      wait_cyc(1);
      chk("spi_wr_en_we", {ram_en, ram_we}, 2'b11);
      chk("spi_wr_addr", ram_addr, 8'h12);
      chk("spi_wr_din", ram_din, 8'hA5);
      wait_cyc(3);

      // SPI read: tx_valid four clocks after the read strobe
      spi(2'b10, 8'h12);
      spi(2'b11, 8'h00);
      wait_cyc(2);
      chk("spi_rd_not_early", tx_valid, 0);
      wait_cyc(1);
      chk("spi_rd_tx_valid", tx_valid, 1);
      chk("spi_rd_tx_data", tx_data, 8'hA5);
      wait_cyc(3);

      // uncontested host write: grant the cycle after the request; last grant now host
      host_access(1'b1, 8'h30, 8'h77, rd, w);
      chk("host_wr_wait", w, 1);
      wait_cyc(1);
      chk("host_wr_mem", mem[8'h30], 8'h77);
      wait_cyc(2);

      // first conflict: SPI served first, then host
      gq.delete();
      spi(2'b00, 8'h12);
      spi(2'b01, 8'h5A);
      host_access(1'b0, 8'h12, 8'h00, rd, w);
      chk("conflict1_host_wait", w, 3);
      chk("conflict1_host_rdata", rd, 8'h5A);
      wait_cyc(2);
      spi(2'b11, 8'h00);           // lone SPI read leaves SPI as last granted
      wait_cyc(5);
      // second conflict: host served first
      spi(2'b01, 8'h66);
      host_access(1'b1, 8'h40, 8'h99, rd, w);
      chk("conflict2_host_wait", w, 1);
      wait_cyc(5);
      chk("grant_count", gq.size(), 5);
      order = '0;
      for (int i = 0; i < 5 && i < gq.size(); i++) order[4-i] = gq[i];
      chk("grant_order", order, 5'b01010);

      // overflow: two data strobes while the host read holds the port
      spi(2'b00, 8'h50);
      wait_cyc(1);
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
      wait_cyc(1);
      chk("ovf_host_gnt", host_gnt, 1);
      host_req = 1'b0;
      spi(2'b01, 8'h31);
      spi(2'b01, 8'h32);
      chk("ovf_host_rvalid", host_rvalid, 1);
      chk("ovf_host_rdata", host_rdata, 8'h99);
      chk("ovf_flag", spi_ovf, 1);
      wait_cyc(5);
      chk("ovf_first_written", mem[8'h50], 8'h31);
      chk("ovf_second_dropped", mem[8'h51], 8'h00);

      // address wrap / auto-increment
      spi(2'b00, 8'hFF);
      spi(2'b01, 8'h11);
      wait_cyc(4);
      spi(2'b01, 8'h22);
      wait_cyc(4);
`ifdef SPI_ARB_AUTO_INC_EN
      chk("inc_mem_ff", mem[8'hFF], 8'h11);
      chk("inc_mem_00", mem[8'h00], 8'h22);
`else
      chk("noinc_mem_ff", mem[8'hFF], 8'h22);
      chk("noinc_mem_00", mem[8'h00], 8'h00);
`endif
      chk("ovf_sticky", spi_ovf, 1);

      // reset in RD_WAIT with an SPI read pending: everything lost
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h12;
      wait_cyc(1);
      chk("rst_case_gnt", host_gnt, 1);
      host_req = 1'b0;
      spi(2'b11, 8'h00);
      rst = 1'b1;
      wait_cyc(1);
      chk("rst_mid_outputs",
          {ram_en, ram_we, ram_addr, ram_din, host_gnt, tx_valid, tx_data, host_rvalid, host_rdata, spi_ovf}, 0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wait_cyc(1);
         chk("rst_quiet", {ram_en, tx_valid, host_rvalid}, 3'b000);
      end
      // wr_addr back to zero after reset
      spi(2'b01, 8'hC3);
      wait_cyc(3);
      chk("post_rst_wr_addr0", mem[8'h00], 8'hC3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Sits between the SPI slave and the single-port RAM: decodes the SPI slave's 10-bit command words into RAM accesses and shares the RAM with a second, parallel host requester. It sequences every RAM cycle, arbitrating round-robin when both sides want the port, and returns read data to the SPI slave (`tx_data`/`tx_valid`) or to the host (`host_rdata`/`host_rvalid`).

## Interface
- `ADDR_WIDTH`, 8, RAM address width; SPI command word width is `ADDR_WIDTH+2`
- `DATA_WIDTH`, 8, RAM data width; must be ≤ `ADDR_WIDTH`
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `rx_data`  in  ADDR_WIDTH+2  SPI command word; [9:8] opcode, [7:0] payload
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid
- `tx_data`  out  DATA_WIDTH  read data to SPI slave
- `tx_valid`  out  1  one-cycle strobe, `tx_data` valid
- `host_req`  in  1  host access request, held until granted
- `host_we`  in  1  1 = write, 0 = read; stable while `host_req`
- `host_addr`  in  ADDR_WIDTH  host address
- `host_wdata`  in  DATA_WIDTH  host write data
- `host_gnt`  out  1  one-cycle pulse, the cycle host access hits the RAM
- `host_rdata`  out  DATA_WIDTH  host read data
- `host_rvalid`  out  1  one-cycle strobe, `host_rdata` valid
- `ram_en`, `ram_we`  out  1  RAM enable / write enable
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_din`  out  DATA_WIDTH  RAM write data
- `ram_dout`  in  DATA_WIDTH  RAM read data, valid the cycle after `ram_en` with `ram_we`=0
- `spi_ovf`  out  1  sticky: SPI data command dropped

## Operation
- Opcodes: 00 latch `wr_addr`←payload; 01 write payload[DATA_WIDTH-1:0] to `wr_addr`; 10 latch `rd_addr`←payload; 11 read `rd_addr` (payload ignored), result on `tx_data`.
- Opcodes 00/10 update address registers on the edge sampling `rx_valid`; no RAM cycle, no arbitration.
- Opcodes 01/11 set a 1-deep pending register (`spi_pend`, opcode, data). `rx_valid` with data opcode while `spi_pend`=1: new command dropped, `spi_ovf`←1 until reset.
- FSM states: IDLE, SPI_ACC, HOST_ACC, RD_WAIT.
  - IDLE: only `spi_pend` → SPI_ACC; only `host_req` → HOST_ACC; both → side not last granted (`last_gnt` register, reset = HOST so SPI wins first conflict).
  - SPI_ACC / HOST_ACC: drive `ram_en`=1, `ram_we`, `ram_addr`, `ram_din`; update `last_gnt`; clear `spi_pend` (SPI); `host_gnt`=1 (host). Write → IDLE; read → RD_WAIT.
  - RD_WAIT: capture `ram_dout` into `tx_data` or `host_rdata` (per owner) → IDLE; matching valid strobe high the following cycle.
- No back-to-back grants without an IDLE cycle; one SPI access max between host accesses when both contend.
- RAM outputs 0 in IDLE/RD_WAIT.

## Timing
- Reset values: `tx_data`, `host_rdata`, `ram_addr`, `ram_din` = 0; `tx_valid`, `host_rvalid`, `host_gnt`, `ram_en`, `ram_we`, `spi_ovf` = 0; `wr_addr`, `rd_addr`, `spi_pend` = 0; state IDLE; `last_gnt` = HOST.
- Uncontested SPI write: `rx_valid` cycle 0 → `ram_en`/`ram_we` cycle 2.
- Uncontested SPI read: `rx_valid` cycle 0 → `ram_en` cycle 2 → `tx_valid` cycle 4.
- Host: `host_req` sampled in IDLE cycle k → `host_gnt`+`ram_en` cycle k+1; read → `host_rvalid` cycle k+3.
- Address latch and auto-increment in the same cycle: latch wins.
- Address wraps modulo 2^ADDR_WIDTH.
- `rst` mid-access: immediate abort, all state to reset values, pending command lost.

## Configuration
- `SPI_ARB_AUTO_INC_EN` defined: after each SPI write access `wr_addr`←`wr_addr`+1; after each SPI read access `rd_addr`←`rd_addr`+1 (wrapping). Host accesses never alter them.
- Undefined: `wr_addr`/`rd_addr` change only on opcodes 00/10.

## Test plan
- Reset, SPI 00 payload 0x12, 01 payload 0xA5 → `ram_en`=`ram_we`=1, `ram_addr`=0x12, `ram_din`=0xA5 two cycles after second `rx_valid`.
- SPI 10 payload 0x12, 11 → `tx_valid` pulse with `tx_data`=0xA5, four cycles after 11 strobe.
- SPI 01 pending and `host_req` read 0x12 in same IDLE cycle → SPI granted first, host granted next arbitration; second simultaneous conflict → host first.
- Two SPI 01 strobes one cycle apart while host holds RAM → second dropped, `spi_ovf`=1, only first written.
- With `SPI_ARB_AUTO_INC_EN`: 00 payload 0xFF, then 01×2 (0x11, 0x22) → RAM[0xFF]=0x11, RAM[0x00]=0x22; without macro both at 0xFF.
- Assert `rst` during RD_WAIT → no `tx_valid`, all outputs 0 next cycle, `spi_pend`=0.
